// File: rtl/img_pkg.sv
// Sprite image ROM base addresses.
package img_pkg;

  localparam int unsigned AdrRocketDef  = 0;
  localparam int unsigned AdrExplodeDef = 16;

endpackage

// File: rtl/vector_pkg.sv
// Shared vector-drawing definitions: rocket FSM states and default launch geometry.
package vector_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFlight,
    StExplode,
    StCooldown
  } rocket_state_e;

  localparam int unsigned XLaunchDef    = 128;
  localparam int unsigned YLaunchDef    = 16;
  localparam int unsigned YRocketEndDef = 240;

endpackage

// File: rtl/hit_window.sv
// Combinational window test: |a - b| <= HALF, using a one-bit-wider difference so nothing wraps.
module hit_window #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned HALF  = 4
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             in_window_o
);

  localparam int unsigned DW = WIDTH + 1;

  logic [WIDTH:0] diff;
  logic [WIDTH:0] mag;

  always_comb begin
    diff        = {1'b0, a_i} - {1'b0, b_i};
    mag         = diff[WIDTH] ? (~diff + 1'b1) : diff;
    in_window_o = (mag <= DW'(HALF));
  end

endmodule

// File: rtl/rocket_control.sv
// Player rocket: launch on fire edge, climb per speed_pulse, hit/explode, cooldown.
// Optional ROCKET_HOMING_EN steers x toward the enemy by one pixel per speed_pulse.
module rocket_control
  import vector_pkg::*;
  import img_pkg::*;
#(
  parameter int unsigned OUT_WIDTH     = 8,
  parameter int unsigned ADDRESSWIDTH  = 8,
  parameter int unsigned X_LAUNCH      = XLaunchDef,
  parameter int unsigned Y_LAUNCH      = YLaunchDef,
  parameter int unsigned Y_ROCKET_END  = YRocketEndDef,
  parameter int unsigned STEP          = 1,
  parameter int unsigned HIT_BOX_X     = 6,
  parameter int unsigned HIT_BOX_Y     = 4,
  parameter int unsigned EXPLODE_TIME  = 3,
  parameter int unsigned COOLDOWN_TIME = 8,
  parameter int unsigned ADR_ROCKET    = AdrRocketDef,
  parameter int unsigned ADR_EXPLODE   = AdrExplodeDef
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fire,
  input  logic                    speed_pulse,
  input  logic [OUT_WIDTH-1:0]    xenemy,
  input  logic [OUT_WIDTH-1:0]    yenemy,
  input  logic                    enemy_spawn,
  output logic [OUT_WIDTH-1:0]    xrocket,
  output logic [OUT_WIDTH-1:0]    yrocket,
  output logic                    rocket_active,
  output logic                    rockethit,
  output logic [ADDRESSWIDTH-1:0] adr_rocket
);

  localparam int unsigned W1   = OUT_WIDTH + 1;
  localparam int unsigned CntW = 16;

  localparam logic [OUT_WIDTH-1:0]    XLaunch    = OUT_WIDTH'(X_LAUNCH);
  localparam logic [OUT_WIDTH-1:0]    YLaunch    = OUT_WIDTH'(Y_LAUNCH);
  localparam logic [OUT_WIDTH-1:0]    YEnd       = OUT_WIDTH'(Y_ROCKET_END);
  localparam logic [ADDRESSWIDTH-1:0] AdrRocket  = ADDRESSWIDTH'(ADR_ROCKET);
  localparam logic [ADDRESSWIDTH-1:0] AdrExplode = ADDRESSWIDTH'(ADR_EXPLODE);
  localparam logic [CntW-1:0]         ExpLast    = CntW'(EXPLODE_TIME - 1);
  localparam logic [CntW-1:0]         CoolLast   = CntW'(COOLDOWN_TIME - 1);

  rocket_state_e state_q, state_d;
  logic                    fire_q;
  logic [OUT_WIDTH-1:0]    xrocket_q, xrocket_d;
  logic [OUT_WIDTH-1:0]    yrocket_q, yrocket_d;
  logic                    active_q, active_d;
  logic                    hit_q, hit_d;
  logic [ADDRESSWIDTH-1:0] adr_q, adr_d;
  logic [CntW-1:0]         cnt_q, cnt_d;

  logic           x_in, y_in, hit;
  logic [OUT_WIDTH:0] y_sum;

  hit_window #(
    .WIDTH(OUT_WIDTH),
    .HALF (HIT_BOX_X)
  ) u_hit_x (
    .a_i        (xrocket_q),
    .b_i        (xenemy),
    .in_window_o(x_in)
  );

  hit_window #(
    .WIDTH(OUT_WIDTH),
    .HALF (HIT_BOX_Y)
  ) u_hit_y (
    .a_i        (yrocket_q),
    .b_i        (yenemy),
    .in_window_o(y_in)
  );

  assign hit   = enemy_spawn & x_in & y_in;
  assign y_sum = {1'b0, yrocket_q} + W1'(STEP);

  always_comb begin
    state_d   = state_q;
    xrocket_d = xrocket_q;
    yrocket_d = yrocket_q;
    active_d  = active_q;
    hit_d     = 1'b0;
    adr_d     = adr_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (fire && !fire_q) begin
          xrocket_d = XLaunch;
          yrocket_d = YLaunch;
          active_d  = 1'b1;
          adr_d     = AdrRocket;
          cnt_d     = '0;
          state_d   = StFlight;
        end
      end
      StFlight: begin
        // Hit has priority over reaching the top limit; leaving FLIGHT bounds hits to one.
        if (hit) begin
          hit_d   = 1'b1;
          adr_d   = AdrExplode;
          cnt_d   = '0;
          state_d = StExplode;
        end else if (yrocket_q == YEnd) begin
          active_d = 1'b0;
          cnt_d    = '0;
          state_d  = StCooldown;
        end else if (speed_pulse) begin
          if (y_sum >= W1'(Y_ROCKET_END)) yrocket_d = YEnd;
          else                            yrocket_d = y_sum[OUT_WIDTH-1:0];
`ifdef ROCKET_HOMING_EN
          if (enemy_spawn) begin
            if (xrocket_q < xenemy)      xrocket_d = xrocket_q + 1'b1;
            else if (xrocket_q > xenemy) xrocket_d = xrocket_q - 1'b1;
          end
`endif
        end
      end
      StExplode: begin
        if (speed_pulse) begin
          if (cnt_q == ExpLast) begin
            cnt_d    = '0;
            active_d = 1'b0;
            state_d  = StCooldown;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StCooldown: begin
        if (speed_pulse) begin
          if (cnt_q == CoolLast) begin
            cnt_d   = '0;
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      fire_q    <= 1'b0;
      xrocket_q <= XLaunch;
      yrocket_q <= YLaunch;
      active_q  <= 1'b0;
      hit_q     <= 1'b0;
      adr_q     <= AdrRocket;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      fire_q    <= fire;
      xrocket_q <= xrocket_d;
      yrocket_q <= yrocket_d;
      active_q  <= active_d;
      hit_q     <= hit_d;
      adr_q     <= adr_d;
      cnt_q     <= cnt_d;
    end
  end

  assign xrocket       = xrocket_q;
  assign yrocket       = yrocket_q;
  assign rocket_active = active_q;
  assign rockethit     = hit_q;
  assign adr_rocket    = adr_q;

endmodule

// File: tb/tb_rocket_control.sv
// Directed bench for rocket_control: launch, hit, miss, held fire, mid-flight reset, homing.
module tb_rocket_control;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fire = 1'b0;
  logic       speed_pulse = 1'b0;
  logic [7:0] xenemy = 8'd0;
  logic [7:0] yenemy = 8'd0;
  logic       enemy_spawn = 1'b0;
  logic [7:0] xrocket;
  logic [7:0] yrocket;
  logic       rocket_active;
  logic       rockethit;
  logic [7:0] adr_rocket;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned hit_cnt  = 0;
  int unsigned run_len  = 0;
  int unsigned max_run  = 0;

  rocket_control dut (
    .clk          (clk),
    .rst          (rst),
    .fire         (fire),
    .speed_pulse  (speed_pulse),
    .xenemy       (xenemy),
    .yenemy       (yenemy),
    .enemy_spawn  (enemy_spawn),
    .xrocket      (xrocket),
    .yrocket      (yrocket),
    .rocket_active(rocket_active),
    .rockethit    (rockethit),
    .adr_rocket   (adr_rocket)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rockethit) begin
      hit_cnt++;
      run_len++;
      if (run_len > max_run) max_run = run_len;
    end else begin
      run_len = 0;
    end
  end

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // One speed_pulse followed by nine quiet cycles.
  task automatic pulse(input int unsigned n);
    for (int i = 0; i < n; i++) begin
      speed_pulse = 1'b1;
      cycle();
      speed_pulse = 1'b0;
      repeat (9) cycle();
    end
  endtask

  initial begin
    rst = 1'b1;
    cycle();
    cycle();
    check_eq("rst_x", xrocket, 128);
    check_eq("rst_y", yrocket, 16);
    check_eq("rst_active", rocket_active, 0);
    check_eq("rst_hit", rockethit, 0);
    check_eq("rst_adr", adr_rocket, 0);
    rst = 1'b0;
    cycle();

    // Launch into an enemy sitting above the pad.
    enemy_spawn = 1'b1;
    xenemy = 8'd130;
    yenemy = 8'd40;
    fire = 1'b1;
    cycle();
    fire = 1'b0;
    check_eq("launch_x", xrocket, 128);
    check_eq("launch_y", yrocket, 16);
    check_eq("launch_active", rocket_active, 1);
    check_eq("launch_adr", adr_rocket, 0);
    pulse(1);
    check_eq("fly_y17", yrocket, 17);
    pulse(1);
    check_eq("fly_y18", yrocket, 18);
    pulse(17);
    check_eq("pre_hit_y35", yrocket, 35);
    check_eq("pre_hit_cnt", hit_cnt, 0);
`ifndef ROCKET_HOMING_EN
    check_eq("fly_x_fixed", xrocket, 128);
`endif
    pulse(1);
    check_eq("hit_cnt", hit_cnt, 1);
    check_eq("hit_width", max_run, 1);
    check_eq("hit_y_frozen", yrocket, 36);
    check_eq("explode_adr", adr_rocket, 16);
    pulse(2);
    check_eq("explode_y", yrocket, 36);
    check_eq("explode_active", rocket_active, 1);
    pulse(1);
    check_eq("explode_end_active", rocket_active, 0);
    pulse(7);
    fire = 1'b1;
    cycle();
    fire = 1'b0;
    cycle();
    check_eq("cool_fire_ignored", rocket_active, 0);
    pulse(1);

    // Relaunch after cooldown with no enemy; hold fire the whole way.
    enemy_spawn = 1'b0;
    fire = 1'b1;
    cycle();
    check_eq("relaunch_active", rocket_active, 1);
    check_eq("relaunch_y", yrocket, 16);
    check_eq("relaunch_adr", adr_rocket, 0);
    pulse(100);
    fire = 1'b0;
    cycle();
    fire = 1'b1;
    cycle();
    check_eq("flight_refire_y", yrocket, 116);
    pulse(123);
    check_eq("miss_y239", yrocket, 239);
    check_eq("miss_active_pre", rocket_active, 1);
    pulse(1);
    check_eq("miss_y240", yrocket, 240);
    check_eq("miss_active", rocket_active, 0);
    check_eq("miss_x", xrocket, 128);
    check_eq("miss_hit_cnt", hit_cnt, 1);
    pulse(4);
    fire = 1'b0;
    cycle();
    fire = 1'b1;
    cycle();
    check_eq("cool_pulse_ignored", rocket_active, 0);
    pulse(4);
    repeat (3) cycle();
    check_eq("held_fire_no_launch", rocket_active, 0);
    fire = 1'b0;
    cycle();
    fire = 1'b1;
    cycle();
    fire = 1'b0;
    check_eq("after_cool_launch", rocket_active, 1);

    // Abort just before a hit would register.
    enemy_spawn = 1'b1;
    xenemy = 8'd128;
    yenemy = 8'd34;
    pulse(13);
    check_eq("pre_rst_y", yrocket, 29);
    speed_pulse = 1'b1;
    cycle();
    speed_pulse = 1'b0;
    check_eq("pre_rst_y30", yrocket, 30);
    rst = 1'b1;
    cycle();
    check_eq("abort_x", xrocket, 128);
    check_eq("abort_y", yrocket, 16);
    check_eq("abort_active", rocket_active, 0);
    check_eq("abort_hit", rockethit, 0);
    check_eq("abort_adr", adr_rocket, 0);
    rst = 1'b0;
    repeat (5) cycle();
    check_eq("abort_hit_cnt", hit_cnt, 1);
    check_eq("abort_idle", rocket_active, 0);

`ifdef ROCKET_HOMING_EN
    xenemy = 8'd140;
    yenemy = 8'd250;
    fire = 1'b1;
    cycle();
    fire = 1'b0;
    pulse(5);
    check_eq("home_x133", xrocket, 133);
    pulse(7);
    check_eq("home_x140", xrocket, 140);
    pulse(3);
    check_eq("home_hold", xrocket, 140);
    check_eq("home_hit_cnt", hit_cnt, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
